// File: rtl/smart_house_cmd_arbiter.sv
// Round-robin arbiter that serialises actuator commands from several sources onto
// the six-bit house actuator register, with per-device dwell locking and heater/cooler interlock.
module smart_house_cmd_arbiter #(
    parameter int N_REQ = 3,
    parameter int DWELL = 8,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [3*N_REQ-1:0]   req_dev_i,
    input  logic [N_REQ-1:0]     req_on_i,
    output logic [N_REQ-1:0]     req_ack_o,
    output logic [N_REQ-1:0]     req_rej_o,
    output logic [5:0]           dev_state_o,
    output logic                 busy_o
);

    localparam int                N_DEV      = 6;
    localparam int                PTR_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W-1:0]  PTR_LAST   = PTR_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0]  DWELL_C    = CNT_W'(DWELL);
    localparam logic [N_REQ-1:0]  REQ_ONE    = N_REQ'(1);
    localparam logic [2:0]        DEV_COOLER = 3'd4;
    localparam logic [2:0]        DEV_HEATER = 3'd5;
    localparam logic [2:0]        DEV_FIRST_BAD = 3'd6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [2:0]         dev_q, dev_d;
    logic               on_q, on_d;
    logic [5:0]         dev_state_q, dev_state_d;
    logic [CNT_W-1:0]   dwell_q [N_DEV];
    logic [CNT_W-1:0]   dwell_d [N_DEV];

    logic               grant_found_s;
    logic [PTR_W-1:0]   grant_idx_s;
    logic [2:0]         grant_dev_s;
    logic               grant_on_s;
    logic [PTR_W-1:0]   cand_s;

    logic [5:0]         sel_s;
    logic [5:0]         force_s;
    logic               cur_lvl_s;
    logic               locked_s;
    logic               dec_ack_s;
    logic               dec_rej_s;
    logic               dec_apply_s;

    function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= N_REQ) begin
            sum = sum - N_REQ;
        end else begin
            sum = sum;
        end
        return PTR_W'(sum);
    endfunction

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        grant_dev_s   = 3'd0;
        grant_on_s    = 1'b0;
        cand_s        = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand_s = wrap_add(ptr_q, k);
            if (!grant_found_s && req_valid_i[cand_s]) begin
                grant_found_s = 1'b1;
                grant_idx_s   = cand_s;
                grant_dev_s   = req_dev_i[int'(cand_s)*3 +: 3];
                grant_on_s    = req_on_i[cand_s];
            end else begin
                grant_found_s = grant_found_s;
            end
        end
    end

    // Decision for the latched command; out-of-range devices decode to an empty select.
    always_comb begin
        sel_s       = 6'b000001 << dev_q;
        cur_lvl_s   = |(sel_s & dev_state_q);
        locked_s    = 1'b0;
        dec_ack_s   = 1'b0;
        dec_rej_s   = 1'b0;
        dec_apply_s = 1'b0;
        for (int d = 0; d < N_DEV; d++) begin
            locked_s = locked_s | (sel_s[d] && (dwell_q[d] != '0));
        end
        if (state_q == ST_EXEC) begin
            if (dev_q >= DEV_FIRST_BAD) begin
                dec_rej_s = 1'b1;
            end else if (on_q == cur_lvl_s) begin
                dec_ack_s = 1'b1;
            end else if (locked_s) begin
                dec_rej_s = 1'b1;
            end else begin
                dec_ack_s   = 1'b1;
                dec_apply_s = 1'b1;
            end
        end else begin
            dec_ack_s = 1'b0;
        end
    end

    // Actuator and dwell next-state; switching one of heater/cooler on clears the other.
    always_comb begin
        force_s     = 6'b000000;
        force_s[4]  = dec_apply_s && (dev_q == DEV_HEATER) && on_q && dev_state_q[4];
        force_s[5]  = dec_apply_s && (dev_q == DEV_COOLER) && on_q && dev_state_q[5];
        dev_state_d = dev_state_q;
        for (int d = 0; d < N_DEV; d++) begin
            dwell_d[d] = dwell_q[d];
            if (dec_apply_s && sel_s[d]) begin
                dev_state_d[d] = on_q;
                dwell_d[d]     = DWELL_C;
            end else if (force_s[d]) begin
                dev_state_d[d] = 1'b0;
                dwell_d[d]     = DWELL_C;
            end else if (dwell_q[d] != '0) begin
                dwell_d[d]     = dwell_q[d] - CNT_W'(1);
            end else begin
                dwell_d[d]     = '0;
            end
        end
    end

    // FSM next-state and command latch.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        dev_d   = dev_q;
        on_d    = on_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_found_s) begin
                    state_d = ST_EXEC;
                    win_d   = grant_idx_s;
                    dev_d   = grant_dev_s;
                    on_d    = grant_on_s;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                ptr_d   = (win_q == PTR_LAST) ? '0 : win_q + PTR_W'(1);
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer, latched command, actuator and dwell registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            win_q       <= '0;
            dev_q       <= 3'd0;
            on_q        <= 1'b0;
            dev_state_q <= 6'b000000;
            for (int d = 0; d < N_DEV; d++) begin
                dwell_q[d] <= '0;
            end
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            win_q       <= win_d;
            dev_q       <= dev_d;
            on_q        <= on_d;
            dev_state_q <= dev_state_d;
            for (int d = 0; d < N_DEV; d++) begin
                dwell_q[d] <= dwell_d[d];
            end
        end
    end

    assign req_ack_o   = dec_ack_s ? (REQ_ONE << win_q) : '0;
    assign req_rej_o   = dec_rej_s ? (REQ_ONE << win_q) : '0;
    assign dev_state_o = dev_state_q;
    assign busy_o      = (state_q == ST_EXEC);

endmodule
